// File: rtl/vx_writeback_arbiter.sv
// ---------------------------------------------------------------------------
// vx_writeback_arbiter
//
// Shares the single register-file write port between NUM_REQ writeback
// sources (ALU, LSU, CSR/other) with round-robin arbitration. The winner's
// fields are registered (one cycle latency) and drive the register file's
// valid / write-enable / rd / data inputs plus the warp number that selects
// the bank.
//
// Ports:
//   clk                 clock, all state updates on posedge
//   reset_n             asynchronous active-low reset
//   req_valid[N]        per-requester writeback valid
//   req_ready[N]        per-requester accept, combinational, one-hot or zero
//   req_wb[N]           per-requester write_register flag
//   req_warp[N*W]       packed warp numbers, slice i = [W*i +: W]
//   req_rd[N*5]         packed destination registers
//   req_data[N*32]      packed write data
//   in_stall            warp-spawn register copy active, blocks all grants
//   out_valid           registered writeback valid
//   out_write_register  registered write enable (0 when rd == 0)
//   out_warp            registered warp number
//   out_rd              registered destination register
//   out_data            registered write data
//   out_grant_id        registered index of the winning requester
// ---------------------------------------------------------------------------
module vx_writeback_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int WARP_BITS = 3,
  parameter int REQ_BITS  = 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_wb,
  input  logic [NUM_REQ*WARP_BITS-1:0]  req_warp,
  input  logic [NUM_REQ*5-1:0]          req_rd,
  input  logic [NUM_REQ*32-1:0]         req_data,
  input  logic                          in_stall,
  output logic                          out_valid,
  output logic                          out_write_register,
  output logic [WARP_BITS-1:0]          out_warp,
  output logic [4:0]                    out_rd,
  output logic [31:0]                   out_data,
  output logic [REQ_BITS-1:0]           out_grant_id
);

  // Unpacked views of the packed payload buses.
  logic [WARP_BITS-1:0] warp_arr [NUM_REQ];
  logic [4:0]           rd_arr   [NUM_REQ];
  logic [31:0]          data_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign warp_arr[gi] = req_warp[WARP_BITS*gi +: WARP_BITS];
      assign rd_arr[gi]   = req_rd[5*gi +: 5];
      assign data_arr[gi] = req_data[32*gi +: 32];
    end
  endgenerate

  logic [REQ_BITS-1:0] rr_ptr_reg;
  logic [REQ_BITS-1:0] rr_ptr_next;
  logic                grant_found;
  logic                grant_fire;
  logic [REQ_BITS-1:0] grant_idx;
  int                  scan_idx;

  // Scan rr_ptr, rr_ptr+1, ... with wrap-around; first valid index wins.
  // rr_ptr_reg is always < NUM_REQ, so one subtraction is enough to wrap.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = int'(rr_ptr_reg) + k;
      if (scan_idx >= NUM_REQ) begin
        scan_idx = scan_idx - NUM_REQ;
      end
      if (!grant_found && req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = REQ_BITS'(scan_idx);
      end
    end
  end

  // Stall and reset suppress the grant combinationally, so ready drops in
  // the same cycle and nothing can be accepted that would then be lost.
  assign grant_fire = grant_found & ~in_stall & reset_n;

  always_comb begin
    req_ready = '0;
    if (grant_fire) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (grant_fire) begin
      if (grant_idx == REQ_BITS'(NUM_REQ - 1)) begin
        rr_ptr_next = '0;
      end else begin
        rr_ptr_next = grant_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_reg <= '0;
    end else begin
      rr_ptr_reg <= rr_ptr_next;
    end
  end

  // Output register. Payload fields hold between grants; only the valid and
  // write-enable strobes are cleared, so the register file never sees a
  // repeated write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid          <= 1'b0;
      out_write_register <= 1'b0;
      out_warp           <= '0;
      out_rd             <= '0;
      out_data           <= '0;
      out_grant_id       <= '0;
    end else if (grant_fire) begin
      out_valid          <= 1'b1;
      // Writes to r0 are consumed but never committed.
      out_write_register <= req_wb[grant_idx] & (rd_arr[grant_idx] != 5'd0);
      out_warp           <= warp_arr[grant_idx];
      out_rd             <= rd_arr[grant_idx];
      out_data           <= data_arr[grant_idx];
      out_grant_id       <= grant_idx;
    end else begin
      out_valid          <= 1'b0;
      out_write_register <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vx_writeback_arbiter.sv
module tb_vx_writeback_arbiter;

  localparam int NUM_REQ   = 3;
  localparam int WARP_BITS = 3;
  localparam int REQ_BITS  = 2;

  logic                         clk;
  logic                         reset_n;
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ-1:0]           req_wb;
  logic [NUM_REQ*WARP_BITS-1:0] req_warp;
  logic [NUM_REQ*5-1:0]         req_rd;
  logic [NUM_REQ*32-1:0]        req_data;
  logic                         in_stall;
  logic                         out_valid;
  logic                         out_write_register;
  logic [WARP_BITS-1:0]         out_warp;
  logic [4:0]                   out_rd;
  logic [31:0]                  out_data;
  logic [REQ_BITS-1:0]          out_grant_id;

  int pass_cnt  = 0;
  int total_cnt = 0;

  vx_writeback_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .WARP_BITS(WARP_BITS),
    .REQ_BITS (REQ_BITS)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_wb            (req_wb),
    .req_warp          (req_warp),
    .req_rd            (req_rd),
    .req_data          (req_data),
    .in_stall          (in_stall),
    .out_valid         (out_valid),
    .out_write_register(out_write_register),
    .out_warp          (out_warp),
    .out_rd            (out_rd),
    .out_data          (out_data),
    .out_grant_id      (out_grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the negedge; combinational ready is sampled 1 ns later,
  // registered outputs on the negedge after the posedge that captured them.
  task automatic set_req(input int i, input logic v, input logic wb,
                         input logic [WARP_BITS-1:0] w, input logic [4:0] rd,
                         input logic [31:0] d);
    req_valid[i]                        = v;
    req_wb[i]                           = wb;
    req_warp[WARP_BITS*i +: WARP_BITS] = w;
    req_rd[5*i +: 5]                    = rd;
    req_data[32*i +: 32]                = d;
  endtask

  task automatic do_reset();
    in_stall  = 1'b0;
    req_valid = '0;
    reset_n   = 1'b0;
    @(negedge clk);
    reset_n   = 1'b1;
  endtask

  task automatic load_all();
    for (int i = 0; i < NUM_REQ; i++) begin
      set_req(i, 1'b1, 1'b1, WARP_BITS'(i + 1), 5'(10 + i), 32'h1000_0000 + i);
    end
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    in_stall  = 1'b0;
    req_valid = '0;
    req_wb    = '0;
    req_warp  = '0;
    req_rd    = '0;
    req_data  = '0;
    load_all();
    @(negedge clk);
    #1;
    total_cnt++;
    if (req_ready !== 3'b000) $display("FAIL reset_ready: got %b want 000", req_ready);
    else pass_cnt++;
    total_cnt++;
    if (out_valid !== 1'b0 || out_write_register !== 1'b0)
      $display("FAIL reset_valid: got v=%b we=%b want 0/0", out_valid, out_write_register);
    else pass_cnt++;
    total_cnt++;
    if (out_warp !== '0 || out_rd !== '0 || out_data !== '0 || out_grant_id !== '0)
      $display("FAIL reset_payload: got warp=%0d rd=%0d data=%h id=%0d want all 0",
               out_warp, out_rd, out_data, out_grant_id);
    else pass_cnt++;
    req_valid = '0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    set_req(0, 1'b1, 1'b1, 3'd2, 5'd5, 32'hDEADBEEF);
    #1;
    total_cnt++;
    if (req_ready !== 3'b001) $display("FAIL single_ready: got %b want 001", req_ready);
    else pass_cnt++;
    @(negedge clk);
    req_valid = '0;
    $display("single: v=%b we=%b warp=%0d rd=%0d data=%h id=%0d",
             out_valid, out_write_register, out_warp, out_rd, out_data, out_grant_id);
    total_cnt++;
    if (out_valid !== 1'b1 || out_write_register !== 1'b1)
      $display("FAIL single_valid: got v=%b we=%b want 1/1", out_valid, out_write_register);
    else pass_cnt++;
    total_cnt++;
    if (out_warp !== 3'd2 || out_rd !== 5'd5 || out_data !== 32'hDEADBEEF || out_grant_id !== 2'd0)
      $display("FAIL single_payload: got warp=%0d rd=%0d data=%h id=%0d want 2/5/deadbeef/0",
               out_warp, out_rd, out_data, out_grant_id);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL single_drop: got v=%b want 0", out_valid);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic [NUM_REQ-1:0] exp_ready;
    int                 prev;
    do_reset();
    load_all();
    for (int c = 0; c < 6; c++) begin
      #1;
      exp_ready = 3'b001 << (c % 3);
      total_cnt++;
      if (req_ready !== exp_ready)
        $display("FAIL rr_ready[%0d]: got %b want %b", c, req_ready, exp_ready);
      else pass_cnt++;
      if (c > 0) begin
        prev = (c - 1) % 3;
        $display("rr cycle %0d: ready=%b out_v=%b id=%0d data=%h",
                 c, req_ready, out_valid, out_grant_id, out_data);
        total_cnt++;
        if (out_valid !== 1'b1 || out_grant_id !== 2'(prev) || out_data !== 32'h1000_0000 + prev)
          $display("FAIL rr_out[%0d]: got v=%b id=%0d data=%h want 1/%0d/%h",
                   c, out_valid, out_grant_id, out_data, prev, 32'h1000_0000 + prev);
        else pass_cnt++;
      end
      @(negedge clk);
    end
    total_cnt++;
    if (out_valid !== 1'b1 || out_grant_id !== 2'd2 || out_warp !== 3'd3 || out_rd !== 5'd12)
      $display("FAIL rr_last: got v=%b id=%0d warp=%0d rd=%0d want 1/2/3/12",
               out_valid, out_grant_id, out_warp, out_rd);
    else pass_cnt++;
    req_valid = '0;
  endtask

  task automatic test_wrap();
    do_reset();
    set_req(1, 1'b1, 1'b1, 3'd1, 5'd7, 32'h0000_0111);
    #1;
    total_cnt++;
    if (req_ready !== 3'b010) $display("FAIL wrap_first: got %b want 010", req_ready);
    else pass_cnt++;
    @(negedge clk);
    set_req(0, 1'b1, 1'b1, 3'd0, 5'd6, 32'h0000_0100);
    #1;
    total_cnt++;
    if (req_ready !== 3'b001) $display("FAIL wrap_grant0: got %b want 001", req_ready);
    else pass_cnt++;
    @(negedge clk);
    #1;
    total_cnt++;
    if (out_valid !== 1'b1 || out_grant_id !== 2'd0 || out_data !== 32'h0000_0100)
      $display("FAIL wrap_out: got v=%b id=%0d data=%h want 1/0/00000100",
               out_valid, out_grant_id, out_data);
    else pass_cnt++;
    total_cnt++;
    if (req_ready !== 3'b010) $display("FAIL wrap_ptr1: got %b want 010", req_ready);
    else pass_cnt++;
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic test_rd_zero();
    do_reset();
    set_req(1, 1'b1, 1'b1, 3'd4, 5'd0, 32'h0000_0055);
    @(negedge clk);
    total_cnt++;
    if (out_valid !== 1'b1 || out_write_register !== 1'b0 || out_rd !== 5'd0 || out_grant_id !== 2'd1)
      $display("FAIL rd0_out: got v=%b we=%b rd=%0d id=%0d want 1/0/0/1",
               out_valid, out_write_register, out_rd, out_grant_id);
    else pass_cnt++;
    set_req(1, 1'b1, 1'b0, 3'd4, 5'd3, 32'h0000_0066);
    @(negedge clk);
    total_cnt++;
    if (out_valid !== 1'b1 || out_write_register !== 1'b0 || out_rd !== 5'd3)
      $display("FAIL wb0_out: got v=%b we=%b rd=%0d want 1/0/3",
               out_valid, out_write_register, out_rd);
    else pass_cnt++;
    req_valid = '0;
    @(negedge clk);
    total_cnt++;
    if (out_valid !== 1'b0 || out_rd !== 5'd3 || out_data !== 32'h0000_0066 || out_warp !== 3'd4)
      $display("FAIL idle_hold: got v=%b rd=%0d data=%h warp=%0d want 0/3/00000066/4",
               out_valid, out_rd, out_data, out_warp);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    do_reset();
    load_all();
    set_req(0, 1'b1, 1'b1, 3'd5, 5'd9, 32'h0000_00A0);
    #1;
    total_cnt++;
    if (req_ready !== 3'b001) $display("FAIL stall_pre: got %b want 001", req_ready);
    else pass_cnt++;
    @(negedge clk);
    in_stall = 1'b1;
    #1;
    total_cnt++;
    if (out_valid !== 1'b1 || out_grant_id !== 2'd0)
      $display("FAIL stall_first_out: got v=%b id=%0d want 1/0", out_valid, out_grant_id);
    else pass_cnt++;
    total_cnt++;
    if (req_ready !== 3'b000) $display("FAIL stall_ready0: got %b want 000", req_ready);
    else pass_cnt++;
    for (int c = 1; c < 4; c++) begin
      @(negedge clk);
      #1;
      total_cnt++;
      if (out_valid !== 1'b0 || req_ready !== 3'b000 || out_data !== 32'h0000_00A0)
        $display("FAIL stall_cycle[%0d]: got v=%b ready=%b data=%h want 0/000/000000a0",
                 c, out_valid, req_ready, out_data);
      else pass_cnt++;
    end
    @(negedge clk);
    in_stall = 1'b0;
    #1;
    total_cnt++;
    if (req_ready !== 3'b010) $display("FAIL stall_resume: got %b want 010", req_ready);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (out_valid !== 1'b1 || out_grant_id !== 2'd1 || out_data !== 32'h1000_0001)
      $display("FAIL stall_resume_out: got v=%b id=%0d data=%h want 1/1/10000001",
               out_valid, out_grant_id, out_data);
    else pass_cnt++;
    req_valid = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    load_all();
    @(negedge clk);
    @(negedge clk);
    total_cnt++;
    if (out_valid !== 1'b1 || out_grant_id !== 2'd1)
      $display("FAIL rstmid_pre: got v=%b id=%0d want 1/1", out_valid, out_grant_id);
    else pass_cnt++;
    #2;
    reset_n = 1'b0;
    #1;
    total_cnt++;
    if (out_valid !== 1'b0 || out_write_register !== 1'b0 || out_data !== 32'd0 || out_grant_id !== 2'd0)
      $display("FAIL rstmid_async: got v=%b we=%b data=%h id=%0d want 0/0/0/0",
               out_valid, out_write_register, out_data, out_grant_id);
    else pass_cnt++;
    total_cnt++;
    if (req_ready !== 3'b000) $display("FAIL rstmid_ready: got %b want 000", req_ready);
    else pass_cnt++;
    @(negedge clk);
    reset_n = 1'b1;
    req_valid[0] = 1'b0;
    #1;
    total_cnt++;
    if (req_ready !== 3'b010) $display("FAIL rstmid_first: got %b want 010", req_ready);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (out_valid !== 1'b1 || out_grant_id !== 2'd1)
      $display("FAIL rstmid_out: got v=%b id=%0d want 1/1", out_valid, out_grant_id);
    else pass_cnt++;
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_rd_zero();
    test_stall();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
